matrix_mult_seq: RTL and testbench
==================================

// Module: matrix_mult_seq
// PURPOSE
// Sequential signed matrix multiplier for the coprocessor datapath. Computes C = A x B for square
// matrices of run-time size 1..DIM using one shared multiply-accumulate unit, instead of a fully
// combinational array. Uses a start/busy/done handshake and selectable wrap or saturate output.
// Matrices are flat row-major buses; element (i,j) sits at bits [(i*DIM+j)*DATA_W +: DATA_W].
// PARAMETERS
// DIM     5  maximum matrix dimension; buses are DIM*DIM*DATA_W bits wide
// DATA_W  8  element width, two's-complement signed
// (local) SZ_W  = $clog2(DIM+1)                  width of the size port
// (local) ACC_W = 2*DATA_W + $clog2(DIM) + 1     accumulator width; never overflows internally
// PORTS
// clk            in   1               rising-edge clock
// reset          in   1               synchronous, active-high reset
// start          in   1               request; sampled only in IDLE
// size           in   SZ_W            active dimension N; 0 or >DIM is treated as DIM
// sat_en         in   1               1 = saturate results, 0 = wrap (keep low DATA_W bits)
// matrix_a       in   DIM*DIM*DATA_W  operand A, row-major
// matrix_b       in   DIM*DIM*DATA_W  operand B, row-major
// result_out     out  DIM*DIM*DATA_W  product C, row-major; registered
// overflow_flag  out  1               1 if any active element exceeded the DATA_W signed range
// busy           out  1               high from the cycle after start is accepted until DONE
// done           out  1               one-cycle pulse; result_out/overflow_flag valid from this cycle
// BEHAVIOUR
// - Reset: result_out=0, overflow_flag=0, busy=0, done=0. FSM goes to IDLE; all indices clear.
// - Reset mid-operation aborts immediately. No partial result is ever written to result_out.
// - FSM states: IDLE -> MAC -> WRITE -> (MAC | DONE) -> IDLE.
// - IDLE, start=1 at an edge: latch matrix_a, matrix_b, N, sat_en. Clear i,j,k, acc and the
//   internal overflow accumulator. Go to MAC. Inputs may change freely after this edge.
// - MAC: each cycle, acc += A[i][k]*B[k][j] (full-precision signed). k increments; after k=N-1, go to WRITE.
// - WRITE (1 cycle): convert acc and store it into the internal result buffer at (i,j).
//   If acc > 2^(DATA_W-1)-1 or acc < -2^(DATA_W-1), set the overflow accumulator (both modes).
//   Conversion: sat_en=1 clamps to the max/min value; sat_en=0 takes acc[DATA_W-1:0].
//   Then clear acc and k, and advance j (wrapping to 0 and incrementing i at j=N-1).
//   After (N-1,N-1), go to DONE; otherwise go to MAC.
// - DONE (1 cycle): copy the buffer to result_out and the overflow accumulator to overflow_flag.
//   done=1, busy=0. Next state is IDLE.
// - Elements with i>=N or j>=N are written as 0. A/B elements outside NxN are ignored.
// - Latency: start is accepted at edge E0. busy=1 from E0 until DONE; done=1 in the cycle
//   following edge E0 + N*N*(N+1) + 1. N=5: 151 cycles. N=2: 13 cycles. N=1: 3 cycles.
// - result_out and overflow_flag hold their values until the next DONE or reset.
// - start while busy, or in DONE, is ignored (not queued). start held high in IDLE re-triggers
//   a new operation on every IDLE edge.
// - Changing size/sat_en/matrix inputs while busy has no effect on the running operation.
// TESTING
// 1. N=5: A = identity, B = values 1..25 -> result_out == B; overflow_flag=0; done exactly 151
//    cycles after start.
// 2. N=5, all A=B=127, sat_en=0: every element 80645 -> 0x05 in all 25 slots; overflow_flag=1.
//    Repeat with sat_en=1 -> all 0x7F; overflow_flag=1.
// 3. N=5, A=-128 (0x80), B=127, sat_en=1: every element -81280 -> 0x80; overflow_flag=1.
//    Also A=-1, B=-1 -> all 0x05; overflow_flag=0.
// 4. N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]; the other 21 slots are 0.
//    done arrives 13 cycles after start. Run again with size=0 -> behaves as N=5.
// 5. Pulse start again 4 cycles into a run with different operands -> ignored; the first
//    result is unchanged and only one done pulse occurs.
// 6. Assert reset 20 cycles into a run -> the next cycle shows busy=0, done=0, result_out=0,
//    overflow_flag=0. A new start then completes correctly.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// Sequential signed matrix multiplier: C = A x B for N x N operands (N = 1..DIM)
// using a single shared multiply-accumulate unit with a start/busy/done handshake.
// Results are wrapped or saturated to DATA_W bits; overflow is reported per run.
module matrix_mult_seq #(
    parameter int DIM    = 5,
    parameter int DATA_W = 8,
    localparam int SZ_W  = $clog2(DIM + 1),
    localparam int BUS_W = DIM * DIM * DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SZ_W-1:0]  size,
    input  logic             sat_en,
    input  logic [BUS_W-1:0] matrix_a,
    input  logic [BUS_W-1:0] matrix_b,
    output logic [BUS_W-1:0] result_out,
    output logic             overflow_flag,
    output logic             busy,
    output logic             done
);

    localparam int ACC_W = 2 * DATA_W + $clog2(DIM) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic [DATA_W-1:0]       SAT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]       SAT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } state_t;

    state_t state, next_state;

    logic [BUS_W-1:0]        a_lat, b_lat, buffer;
    logic [SZ_W-1:0]         n_lat, n_last;
    logic                    sat_lat;
    logic [SZ_W-1:0]         i, j, k;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf_acc;

    int                        a_base, b_base, w_base;
    logic signed [DATA_W-1:0]  a_elem, b_elem;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      over_hi, over_lo;
    logic [DATA_W-1:0]         conv;
    logic [SZ_W-1:0]           n_eff;

    // Operand fetch, MAC product and result conversion
    always_comb begin
        a_base   = (int'(i) * DIM + int'(k)) * DATA_W;
        b_base   = (int'(k) * DIM + int'(j)) * DATA_W;
        w_base   = (int'(i) * DIM + int'(j)) * DATA_W;
        a_elem   = a_lat[a_base +: DATA_W];
        b_elem   = b_lat[b_base +: DATA_W];
        prod     = a_elem * b_elem;
        prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
        over_hi  = (acc > ACC_MAX);
        over_lo  = (acc < ACC_MIN);
        conv     = acc[DATA_W-1:0];
        if (sat_lat && over_hi) conv = SAT_MAX;
        if (sat_lat && over_lo) conv = SAT_MIN;
        n_last   = n_lat - SZ_W'(1);
        n_eff    = size;
        if (size == '0 || size > SZ_W'(DIM)) n_eff = SZ_W'(DIM);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state and busy decode
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE:  if (start) next_state = MAC;
            MAC: begin
                busy = 1'b1;
                if (k == n_last) next_state = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (i == n_last && j == n_last) next_state = DONE;
                else                            next_state = MAC;
            end
            DONE: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, accumulation, buffer writes and result publish
    always_ff @(posedge clk) begin
        if (reset) begin
            a_lat         <= '0;
            b_lat         <= '0;
            buffer        <= '0;
            n_lat         <= '0;
            sat_lat       <= 1'b0;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            acc           <= '0;
            ovf_acc       <= 1'b0;
            result_out    <= '0;
            overflow_flag <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_lat   <= matrix_a;
                    b_lat   <= matrix_b;
                    n_lat   <= n_eff;
                    sat_lat <= sat_en;
                    i       <= '0;
                    j       <= '0;
                    k       <= '0;
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                    // cleared here so slots outside the active NxN read as 0
                    buffer  <= '0;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + SZ_W'(1);
                end
                WRITE: begin
                    if (over_hi || over_lo) ovf_acc <= 1'b1;
                    buffer[w_base +: DATA_W] <= conv;
                    acc <= '0;
                    k   <= '0;
                    if (j == n_last) begin
                        j <= '0;
                        i <= i + SZ_W'(1);
                    end else begin
                        j <= j + SZ_W'(1);
                    end
                end
                DONE: begin
                    // done is registered so it rises together with result_out
                    result_out    <= buffer;
                    overflow_flag <= ovf_acc;
                    done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed self-checking bench for matrix_mult_seq with hand-computed expectations.
module tb_matrix_mult_seq;

    localparam int DIM   = 5;
    localparam int DW    = 8;
    localparam int SZ_W  = 3;
    localparam int BUS_W = DIM * DIM * DW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [SZ_W-1:0]  size = '0;
    logic             sat_en = 1'b0;
    logic [BUS_W-1:0] matrix_a = '0;
    logic [BUS_W-1:0] matrix_b = '0;
    logic [BUS_W-1:0] result_out;
    logic             overflow_flag;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    matrix_mult_seq #(.DIM(DIM), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .size(size),
        .sat_en(sat_en),
        .matrix_a(matrix_a),
        .matrix_b(matrix_b),
        .result_out(result_out),
        .overflow_flag(overflow_flag),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] fill(input logic [DW-1:0] v);
        logic [BUS_W-1:0] r;
        for (int e = 0; e < DIM * DIM; e++) r[e*DW +: DW] = v;
        return r;
    endfunction

    // Pulse start, then wait (bounded) for done and check latency and handshake
    task automatic run(input string tag, input int exp_lat);
        int cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_val({tag, "_busy"}, 32'(busy), 32'd1);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) seen = 1'b1;
        end
        chk_val({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        chk_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [BUS_W-1:0] ident, seq, exp, a2, b2;
        int dones, first_lat;

        ident = '0;
        seq   = '0;
        for (int r = 0; r < DIM; r++) ident[(r*DIM + r)*DW +: DW] = 8'd1;
        for (int e = 0; e < DIM * DIM; e++) seq[e*DW +: DW] = DW'(e + 1);

        a2 = fill(8'h11);
        b2 = fill(8'h22);
        a2[0*DW +: DW] = 8'd1;  a2[1*DW +: DW] = 8'd2;
        a2[5*DW +: DW] = 8'd3;  a2[6*DW +: DW] = 8'd4;
        b2[0*DW +: DW] = 8'd5;  b2[1*DW +: DW] = 8'd6;
        b2[5*DW +: DW] = 8'd7;  b2[6*DW +: DW] = 8'd8;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_bus("rst_result", result_out, '0);
        chk_val("rst_ovf", 32'(overflow_flag), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);

        // Identity x 1..25
        size = 3'd5; sat_en = 1'b0; matrix_a = ident; matrix_b = seq;
        run("ident", 151);
        chk_bus("ident_res", result_out, seq);
        chk_val("ident_ovf", 32'(overflow_flag), 32'd0);

        // All 127, wrap then saturate
        matrix_a = fill(8'h7F); matrix_b = fill(8'h7F); sat_en = 1'b0;
        run("wrap127", 151);
        chk_bus("wrap127_res", result_out, fill(8'h05));
        chk_val("wrap127_ovf", 32'(overflow_flag), 32'd1);
        sat_en = 1'b1;
        run("sat127", 151);
        chk_bus("sat127_res", result_out, fill(8'h7F));
        chk_val("sat127_ovf", 32'(overflow_flag), 32'd1);

        // Negative saturation, and -1 x -1
        matrix_a = fill(8'h80); matrix_b = fill(8'h7F);
        run("satneg", 151);
        chk_bus("satneg_res", result_out, fill(8'h80));
        chk_val("satneg_ovf", 32'(overflow_flag), 32'd1);
        matrix_a = fill(8'hFF); matrix_b = fill(8'hFF);
        run("m1", 151);
        chk_bus("m1_res", result_out, fill(8'h05));
        chk_val("m1_ovf", 32'(overflow_flag), 32'd0);

        // N=2 with junk outside the active window
        exp = '0;
        exp[0*DW +: DW] = 8'd19; exp[1*DW +: DW] = 8'd22;
        exp[5*DW +: DW] = 8'd43; exp[6*DW +: DW] = 8'd50;
        size = 3'd2; sat_en = 1'b0; matrix_a = a2; matrix_b = b2;
        run("n2", 13);
        chk_bus("n2_res", result_out, exp);
        chk_val("n2_ovf", 32'(overflow_flag), 32'd0);

        // N=1: -3 * 7 = -21
        size = 3'd1; matrix_a = fill(8'hFD); matrix_b = fill(8'h07);
        run("n1", 3);
        chk_bus("n1_res", result_out, {{(BUS_W-DW){1'b0}}, 8'hEB});

        // size=0 and size>DIM both mean N=5
        size = 3'd0; matrix_a = ident; matrix_b = seq;
        run("sz0", 151);
        chk_bus("sz0_res", result_out, seq);
        size = 3'd7; matrix_a = seq; matrix_b = ident;
        run("sz7", 151);
        chk_bus("sz7_res", result_out, seq);

        // Start pulse mid-run is ignored
        size = 3'd2; matrix_a = a2; matrix_b = b2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first_lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                size = 3'd5; matrix_a = fill(8'h7F); matrix_b = fill(8'h7F);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (first_lat == 0) first_lat = c;
            end
        end
        chk_val("ign_dones", 32'(dones), 32'd1);
        chk_val("ign_lat", 32'(first_lat), 32'd13);
        chk_bus("ign_res", result_out, exp);
        chk_val("ign_busy_idle", 32'(busy), 32'd0);

        // Reset 20 cycles into a run aborts it
        size = 3'd5; sat_en = 1'b1; matrix_a = fill(8'h7F); matrix_b = fill(8'h7F);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_val("abort_busy", 32'(busy), 32'd0);
        chk_val("abort_done", 32'(done), 32'd0);
        chk_bus("abort_res", result_out, '0);
        chk_val("abort_ovf", 32'(overflow_flag), 32'd0);
        reset = 1'b0;

        size = 3'd2; sat_en = 1'b0; matrix_a = a2; matrix_b = b2;
        run("post", 13);
        chk_bus("post_res", result_out, exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
